// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the Tx framer and the Rx side:
// state encodings, frame-format limits and a parity helper.
package uart_pkg;

   // Legal frame-format ranges
   localparam int UART_MIN_DATA_BITS = 5;
   localparam int UART_MAX_DATA_BITS = 8;
   localparam int UART_MIN_STOP_BITS = 1;
   localparam int UART_MAX_STOP_BITS = 2;

   // Frame sequencing states. PARITY is only visited when parity is built in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_state_e;

   // Parity over a zero-extended data word. Unused upper bits are zero and
   // do not affect the XOR. Setting odd inverts the even-parity result.
   function automatic logic parity_bit(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic                          odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word on tx_valid/tx_ready, waits for the
// next bit_tick to align, then shifts out start, data (LSB first), optional
// parity and stop bits, one bit per bit_tick period, and pulses tx_done.
// Optional parity bit is built in when macro UART_TX_PARITY_EN is defined.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 sys_clk,
   input  logic                 reset,
   input  logic                 bit_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 txd
);

   localparam int             CNT_W     = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_e          state, state_nxt;
   logic [DATA_BITS-1:0] shift_q, shift_nxt;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic                 stop_cnt, stop_cnt_nxt;
   logic                 txd_q, txd_nxt;
   logic                 done_q, done_nxt;

`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_nxt;
`else
   // Odd/even selection only matters when parity is built in.
   logic                 unused_parity_cfg;
   assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

   // State and datapath registers; reset forces an idle-high line.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         // NOTE: the shift register is a handful of flops, not a RAM, so it is
         // cleared with everything else to keep post-reset state deterministic.
         shift_q  <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         txd_q    <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed by the combinational block.
         state    <= state_nxt;
         shift_q  <= shift_nxt;
         bit_cnt  <= bit_cnt_nxt;
         stop_cnt <= stop_cnt_nxt;
         txd_q    <= txd_nxt;
         done_q   <= done_nxt;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_nxt;
`endif
      end
   end

   // Next-state and next-datapath logic; only acceptance ignores bit_tick.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path
      // through the case statement can infer a latch.
      state_nxt    = state;
      shift_nxt    = shift_q;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      txd_nxt      = txd_q;
      done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_nxt   = parity_q;
`endif

      unique case (state)
         ST_IDLE: begin
            if (tx_valid) begin
               shift_nxt = tx_data;
               state_nxt = ST_WAIT;
`ifdef UART_TX_PARITY_EN
               parity_nxt = parity_bit(UART_MAX_DATA_BITS'(tx_data), PARITY_ODD != 0);
`endif
            end
         end

         ST_WAIT: begin
            if (bit_tick) begin
               state_nxt = ST_START;
               txd_nxt   = 1'b0;
            end
         end

         ST_START: begin
            if (bit_tick) begin
               state_nxt   = ST_DATA;
               txd_nxt     = shift_q[0];
               bit_cnt_nxt = '0;
            end
         end

         ST_DATA: begin
            if (bit_tick) begin
               if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt    = ST_PARITY;
                  txd_nxt      = parity_q;
`else
                  state_nxt    = ST_STOP;
                  txd_nxt      = 1'b1;
                  stop_cnt_nxt = 1'b0;
`endif
               end else begin
                  shift_nxt   = shift_q >> 1;
                  txd_nxt     = shift_q[1];
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) begin
               state_nxt    = ST_STOP;
               txd_nxt      = 1'b1;
               stop_cnt_nxt = 1'b0;
            end
         end
`endif

         ST_STOP: begin
            if (bit_tick) begin
               if (stop_cnt == LAST_STOP) begin
                  state_nxt    = ST_IDLE;
                  done_nxt     = 1'b1;
                  stop_cnt_nxt = 1'b0;
               end else begin
                  stop_cnt_nxt = stop_cnt + 1'b1;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            txd_nxt   = 1'b1;
         end
      endcase
   end

   assign tx_ready = (state == ST_IDLE);
   assign tx_busy  = ~tx_ready;
   assign tx_done  = done_q;
   assign txd      = txd_q;

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity (used only with UART_TX_PARITY_EN).
REQ-004 The block SHALL have the following ports, clock and reset first:
- sys_clk  input  1  clock, positive edge.
- reset  input  1  reset, asynchronous, active-high.
- bit_tick  input  1  one-sys_clk-wide baud pulse from the Tx clock generator.
- tx_data  input  DATA_BITS  byte to send, LSB first.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte.
- tx_busy  output  1  frame pending or in progress.
- tx_done  output  1  one-cycle pulse at frame end.
- txd  output  1  serial line, idle high.

Function
REQ-005 Acceptance SHALL occur on a sys_clk edge where tx_valid and tx_ready are both 1; tx_data SHALL be latched into a shift register on that edge.
REQ-006 tx_ready SHALL be 1 only in state IDLE; tx_busy SHALL be the inverse of tx_ready.
REQ-007 States SHALL be IDLE, WAIT, START, DATA, PARITY, STOP; all transitions and txd updates, except IDLE->WAIT, SHALL occur only on edges where bit_tick is 1.
REQ-008 The IDLE->WAIT transition SHALL occur on acceptance, regardless of bit_tick in that cycle.
REQ-009 The WAIT->START transition SHALL occur on the next bit_tick, with txd registered to 0 on that edge.
REQ-010 The START->DATA transition SHALL occur on bit_tick, with txd set to shift[0] and the bit counter cleared to 0.
REQ-011 In DATA, on bit_tick, the block SHALL shift right and drive the next bit while bit_cnt < DATA_BITS-1; at bit_cnt == DATA_BITS-1 it SHALL go to PARITY if enabled, else to STOP with txd=1.
REQ-012 The PARITY->STOP transition SHALL occur on bit_tick with txd=1.
REQ-013 In STOP, each bit_tick SHALL increment the stop counter; on the tick where stop_cnt == STOP_BITS-1 the block SHALL go to IDLE and pulse tx_done for exactly one cycle.
REQ-014 Every bit on txd SHALL therefore last exactly one bit_tick period.
REQ-015 tx_valid asserted outside IDLE SHALL be ignored, with no data corruption.
REQ-016 The block SHALL accept a new byte in the cycle after tx_done (back-to-back frames) with no extra idle bit beyond the stop bits and the WAIT alignment.
REQ-017 Counters SHALL be sized $clog2(DATA_BITS) and 1 bit and SHALL NOT wrap outside the states above.

Reset
REQ-018 On reset, within the same cycle (asynchronous), the block SHALL force state IDLE, txd=1, tx_ready=1, tx_busy=0, tx_done=0, and clear the counters and shift register.
REQ-019 Reset asserted mid-frame SHALL abort the frame; after release, the first acceptance SHALL start a fresh frame.

Configuration
REQ-020 The feature SHALL be controlled by macro UART_TX_PARITY_EN.
REQ-021 With UART_TX_PARITY_EN defined, the PARITY state SHALL exist, and the parity bit SHALL be the XOR of the latched data bits, inverted when PARITY_ODD=1.
REQ-022 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-023 State encodings and localparams for the frame limits (max DATA_BITS, STOP_BITS range) SHALL live in shared package uart_pkg, also used by the Rx side.
REQ-024 No sub-module SHALL be instantiated; uart_tx_clk_gen SHALL be instantiated alongside the framer at the top level, driving bit_tick.

Verification
REQ-025 The bench SHALL drive bit_tick every 16 sys_clk, DATA_BITS=8, STOP_BITS=1, parity off.
REQ-026 Scenario: send 0x55 -> txd = 0,1,0,1,0,1,0,1,0,1, each 16 cycles; tx_done pulses once; tx_ready returns to 1.
REQ-027 Scenario: parity on, even, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11 bits.
REQ-028 Scenario: tx_valid held high with 0xA3 then 0x3C -> two contiguous frames; the second start bit begins on the first bit_tick after WAIT; no byte lost.
REQ-029 Scenario: acceptance in the same cycle as bit_tick -> start bit begins on the following tick, not the current one.
REQ-030 Scenario: reset pulsed during DATA bit 4 -> txd=1 immediately, tx_ready=1; the next byte 0xF0 is sent correctly.
REQ-031 Scenario: STOP_BITS=2, send 0x00 -> txd high for 32 cycles before tx_done; tx_valid pulsed during the frame is ignored.
